// File: rtl/atm_keypad_pkg.sv
// Shared encodings for the ATM keypad front end: FSM states, control key codes
// and PIN geometry.
package atm_keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACC_ENTRY = 3'd1,
    ST_PIN_ENTRY = 3'd2,
    ST_VERIFY    = 3'd3,
    ST_SESSION   = 3'd4,
    ST_LOCKED    = 3'd5
  } state_t;

  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  localparam int PIN_DIGITS = 4;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/atm_keypad_frontend_timer.sv
// Loadable down-counter: load presets MAX_COUNT-1, enable counts toward zero,
// expire flags the enabled terminal-count cycle.
module atm_cycle_timer #(
  parameter int unsigned MAX_COUNT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(MAX_COUNT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = LOAD_VAL;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/atm_keypad_frontend.sv
// Keypad credential collector and attempt/lock sequencer for the ATM core.
// Optional inactivity abort is built when ATM_KEYPAD_TIMEOUT_EN is defined.
module atm_keypad_frontend
  import atm_keypad_pkg::*;
#(
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned LOCK_CYCLES    = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        auth_valid,
  input  logic        auth_ok,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic        cred_valid,
  output logic [2:0]  state,
  output logic [1:0]  attempts_left,
  output logic        locked,
  output logic        timeout
);

  localparam logic [1:0] ATT_MAX = 2'(MAX_ATTEMPTS);

  if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 3) begin : g_bad_attempts
    $error("MAX_ATTEMPTS must be 1..3");
  end
  if (TIMEOUT_CYCLES < 2 || LOCK_CYCLES < 2) begin : g_bad_cycles
    $error("TIMEOUT_CYCLES and LOCK_CYCLES must be at least 2");
  end

  state_t      state_q, state_d;
  logic [3:0]  acc_q, acc_d;
  logic [15:0] pin_q, pin_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  att_q, att_d;
  logic        cred_q, cred_d, locked_q, locked_d, tmo_q, tmo_d;
  logic        lock_exp, tmo_exp;

  // A key arriving with the card-removal edge is dropped.
  logic key_ok, key_dig, key_ent, key_clr, key_can;
  assign key_ok  = key_valid && card_in;
  assign key_dig = key_ok && is_digit(key_code);
  assign key_ent = key_ok && (key_code == KEY_ENTER);
  assign key_clr = key_ok && (key_code == KEY_CLEAR);
  assign key_can = key_ok && (key_code == KEY_CANCEL);

  atm_cycle_timer #(.MAX_COUNT(LOCK_CYCLES)) u_lock_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (state_q != ST_LOCKED),
    .en_i     (state_q == ST_LOCKED),
    .expire_o (lock_exp)
  );

`ifdef ATM_KEYPAD_TIMEOUT_EN
  logic tmo_active;
  assign tmo_active = (state_q == ST_ACC_ENTRY) || (state_q == ST_PIN_ENTRY) ||
                      (state_q == ST_VERIFY)    || (state_q == ST_SESSION);

  atm_cycle_timer #(.MAX_COUNT(TIMEOUT_CYCLES)) u_tmo_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (!tmo_active || key_valid || auth_valid || (state_d != state_q)),
    .en_i     (tmo_active),
    .expire_o (tmo_exp)
  );
`else
  assign tmo_exp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      pin_q    <= '0;
      cnt_q    <= '0;
      att_q    <= ATT_MAX;
      cred_q   <= 1'b0;
      locked_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      pin_q    <= pin_d;
      cnt_q    <= cnt_d;
      att_q    <= att_d;
      cred_q   <= cred_d;
      locked_q <= locked_d;
      tmo_q    <= tmo_d;
    end
  end

  // Card removal beats timeout, which beats auth results and keys.
  always_comb begin
    state_d = state_q;
    if ((state_q != ST_LOCKED) && (state_q != ST_IDLE) && !card_in)
      state_d = ST_IDLE;
    else if (tmo_exp)
      state_d = ST_IDLE;
    else begin
      unique case (state_q)
        ST_IDLE:      if (card_in) state_d = ST_ACC_ENTRY;
        ST_ACC_ENTRY: if (key_can) state_d = ST_IDLE;
                      else if (key_ent && (cnt_q != '0)) state_d = ST_PIN_ENTRY;
        ST_PIN_ENTRY: if (key_can) state_d = ST_IDLE;
                      else if (key_ent && (cnt_q == 3'(PIN_DIGITS))) state_d = ST_VERIFY;
        ST_VERIFY:    if (auth_valid) begin
                        if (auth_ok)           state_d = ST_SESSION;
                        else if (att_q <= 2'd1) state_d = ST_LOCKED;
                        else                   state_d = ST_PIN_ENTRY;
                      end
        ST_SESSION:   if (key_can) state_d = ST_IDLE;
        ST_LOCKED:    if (lock_exp) state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d = acc_q;
    pin_d = pin_q;
    cnt_d = cnt_q;
    att_d = att_q;
    unique case (state_q)
      ST_ACC_ENTRY: begin
        if (key_dig) begin
          acc_d = key_code;
          cnt_d = 3'd1;
        end else if (state_d == ST_PIN_ENTRY) begin
          cnt_d = '0;
        end
      end
      ST_PIN_ENTRY: begin
        if (key_dig && (cnt_q < 3'(PIN_DIGITS))) begin
          pin_d = {pin_q[11:0], key_code};
          cnt_d = cnt_q + 3'd1;
        end else if (key_clr) begin
          pin_d = '0;
          cnt_d = '0;
        end
      end
      ST_VERIFY: begin
        if (state_d == ST_SESSION) begin
          att_d = ATT_MAX;
        end else if (state_d == ST_LOCKED) begin
          att_d = '0;
        end else if (state_d == ST_PIN_ENTRY) begin
          att_d = att_q - 2'd1;
          pin_d = '0;
          cnt_d = '0;
        end
      end
      ST_LOCKED: if (state_d == ST_IDLE) att_d = ATT_MAX;
      default: ;
    endcase
    if (state_d == ST_IDLE) begin
      acc_d = '0;
      pin_d = '0;
      cnt_d = '0;
    end
    cred_d   = (state_q == ST_PIN_ENTRY) && (state_d == ST_VERIFY);
    locked_d = (state_d == ST_LOCKED);
    tmo_d    = tmo_exp && card_in;
  end

  assign acc_num       = acc_q;
  assign pin           = pin_q;
  assign cred_valid    = cred_q;
  assign state         = state_q;
  assign attempts_left = att_q;
  assign locked        = locked_q;
  assign timeout       = tmo_q;

endmodule
